// File: rtl/riscv_pkg.sv
// Shared control encodings and inter-stage bundles for the pipeline control path.
// Holds ResultSrc/forward/ALU codes, the register-address width and the E/M/W bundles.
package riscv_pkg;

   localparam int REGW = 5;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } res_src_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef struct packed {
      logic [1:0]      result_src;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic            alu_src;
      logic            reg_write;
      logic [2:0]      alu_ctrl;
      logic [REGW-1:0] rs1;
      logic [REGW-1:0] rs2;
      logic [REGW-1:0] rd;
   } id_ex_t;

   typedef struct packed {
      logic            reg_write;
      logic [1:0]      result_src;
      logic            mem_write;
      logic [REGW-1:0] rd;
   } ex_mem_t;

   typedef struct packed {
      logic            reg_write;
      logic [1:0]      result_src;
      logic [REGW-1:0] rd;
   } mem_wb_t;

   // A producer only matters if it really writes a non-x0 register.
   function automatic logic hit(
      input logic [REGW-1:0] rs,
      input logic [REGW-1:0] rd,
      input logic            we
   );
      return we && (rd != '0) && (rs == rd);
   endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-to-datapath control bundle: decoded D-stage control in, staged control,
// branch decision and hazard controls out. master = decoder/datapath, slave = ctrl_pipe.
interface ctrl_pipe_if;
   import riscv_pkg::*;

   logic [1:0]      ResultSrcD;
   logic            MemWriteD;
   logic            BranchD;
   logic            JumpD;
   logic            ALUSrcD;
   logic            RegWriteD;
   logic [2:0]      ALUControlD;
   logic [REGW-1:0] Rs1D;
   logic [REGW-1:0] Rs2D;
   logic [REGW-1:0] RdD;
   logic            ZeroE;

   logic [2:0]      ALUControlE;
   logic            ALUSrcE;
   logic            PCSrcE;
   logic            MemWriteM;
   logic            RegWriteW;
   logic [1:0]      ResultSrcW;
   logic [REGW-1:0] RdW;
   logic [1:0]      ForwardAE;
   logic [1:0]      ForwardBE;
   logic            StallF;
   logic            StallD;
   logic            FlushD;
   logic            FlushE;

   modport master (
      output ResultSrcD, MemWriteD, BranchD, JumpD, ALUSrcD,
      output RegWriteD, ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
      input  ALUControlE, ALUSrcE, PCSrcE, MemWriteM,
      input  RegWriteW, ResultSrcW, RdW, ForwardAE, ForwardBE,
      input  StallF, StallD, FlushD, FlushE
   );

   modport slave (
      input  ResultSrcD, MemWriteD, BranchD, JumpD, ALUSrcD,
      input  RegWriteD, ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
      output ALUControlE, ALUSrcE, PCSrcE, MemWriteM,
      output RegWriteW, ResultSrcW, RdW, ForwardAE, ForwardBE,
      output StallF, StallD, FlushD, FlushE
   );

endinterface

// File: rtl/ctrl_pipe_hazard_unit.sv
// hazard_unit: combinational stall/flush/forward generation from D/E/M/W addresses.
// In: rs1d/rs2d, rs1e/rs2e, rde/rdm/rdw + reg writes, resultsrce, pcsrce. FORWARD_EN selects mode.
module hazard_unit
   import riscv_pkg::*;
(
   input  logic [REGW-1:0] rs1d,
   input  logic [REGW-1:0] rs2d,
   input  logic [REGW-1:0] rs1e,
   input  logic [REGW-1:0] rs2e,
   input  logic [REGW-1:0] rde,
   input  logic [REGW-1:0] rdm,
   input  logic [REGW-1:0] rdw,
   input  logic            regwritee,
   input  logic            regwritem,
   input  logic            regwritew,
   input  logic [1:0]      resultsrce,
   input  logic            pcsrce,
   output logic [1:0]      forwardae,
   output logic [1:0]      forwardbe,
   output logic            stallf,
   output logic            stalld,
   output logic            flushd,
   output logic            flushe
);

   logic stall;

`ifdef FORWARD_EN
   // M is the younger producer, so it wins over W.
   function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] rs);
      if (hit(rs, rdm, regwritem))
         return FWD_M;
      else if (hit(rs, rdw, regwritew))
         return FWD_W;
      else
         return FWD_RF;
   endfunction

   always_comb begin
      forwardae = fwd_sel(rs1e);
      forwardbe = fwd_sel(rs2e);
   end

   // Only a load in E cannot be forwarded in time.
   always_comb begin
      stall = 1'b0;
      if (resultsrce == RES_MEM)
         stall = hit(rs1d, rde, regwritee)
               | hit(rs2d, rde, regwritee);
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{rs1e, rs2e, rdw, regwritew, resultsrce};

   assign forwardae = FWD_RF;
   assign forwardbe = FWD_RF;

   // W needs nothing: the regfile writes on the falling edge.
   always_comb begin
      stall = hit(rs1d, rde, regwritee)
            | hit(rs2d, rde, regwritee)
            | hit(rs1d, rdm, regwritem)
            | hit(rs2d, rdm, regwritem);
   end
`endif

   // A taken branch kills the stalled instruction anyway, so it wins.
   assign stallf = stall & ~pcsrce;
   assign stalld = stall & ~pcsrce;
   assign flushd = pcsrce;
   assign flushe = pcsrce | stall;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: stages decoded control through E/M/W, resolves PCSrcE, hosts hazard_unit.
// Ports: clk, reset (sync, active high), bus (ctrl_pipe_if.slave). FORWARD_EN enables forwarding.
module ctrl_pipe
   import riscv_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   ctrl_pipe_if.slave bus
);

   id_ex_t  d_in;
   id_ex_t  e_q;
   ex_mem_t m_q;
   mem_wb_t w_q;

   logic pcsrce;
   logic flushe;

   always_comb begin
      d_in            = '0;
      d_in.result_src = bus.ResultSrcD;
      d_in.mem_write  = bus.MemWriteD;
      d_in.branch     = bus.BranchD;
      d_in.jump       = bus.JumpD;
      d_in.alu_src    = bus.ALUSrcD;
      d_in.reg_write  = bus.RegWriteD;
      d_in.alu_ctrl   = bus.ALUControlD;
      d_in.rs1        = bus.Rs1D;
      d_in.rs2        = bus.Rs2D;
      d_in.rd         = bus.RdD;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= flushe ? '0 : d_in;
         m_q <= '{reg_write:  e_q.reg_write,
                  result_src: e_q.result_src,
                  mem_write:  e_q.mem_write,
                  rd:         e_q.rd};
         w_q <= '{reg_write:  m_q.reg_write,
                  result_src: m_q.result_src,
                  rd:         m_q.rd};
      end
   end

   assign pcsrce = (e_q.branch & bus.ZeroE) | e_q.jump;

   hazard_unit u_hz (
      .rs1d       (bus.Rs1D),
      .rs2d       (bus.Rs2D),
      .rs1e       (e_q.rs1),
      .rs2e       (e_q.rs2),
      .rde        (e_q.rd),
      .rdm        (m_q.rd),
      .rdw        (w_q.rd),
      .regwritee  (e_q.reg_write),
      .regwritem  (m_q.reg_write),
      .regwritew  (w_q.reg_write),
      .resultsrce (e_q.result_src),
      .pcsrce     (pcsrce),
      .forwardae  (bus.ForwardAE),
      .forwardbe  (bus.ForwardBE),
      .stallf     (bus.StallF),
      .stalld     (bus.StallD),
      .flushd     (bus.FlushD),
      .flushe     (flushe)
   );

   assign bus.FlushE      = flushe;
   assign bus.PCSrcE      = pcsrce;
   assign bus.ALUControlE = e_q.alu_ctrl;
   assign bus.ALUSrcE     = e_q.alu_src;
   assign bus.MemWriteM   = m_q.mem_write;
   assign bus.RegWriteW   = w_q.reg_write;
   assign bus.ResultSrcW  = w_q.result_src;
   assign bus.RdW         = w_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: hand-computed vector table for hazard corner cases,
// then random instruction streams checked against an instruction-level pipeline model.
module tb_ctrl_pipe;
   import riscv_pkg::*;

   typedef struct packed {
      logic [1:0] rs;
      logic       mw;
      logic       br;
      logic       j;
      logic       as;
      logic       rw;
      logic [2:0] alu;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } ins_t;

   typedef struct {
      ins_t       d;
      logic       z;
      logic [8:0] hz;
   } vec_t;

   // hz = {PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}
   localparam logic [8:0] H_0   = 9'h000;
   localparam logic [8:0] H_ST  = 9'h0D0;
   localparam logic [8:0] H_BR  = 9'h130;
   localparam logic [8:0] H_AM  = 9'h008;
   localparam logic [8:0] H_AW  = 9'h004;
   localparam logic [8:0] H_BW  = 9'h001;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ctrl_pipe_if bus();

   ctrl_pipe dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int   tests = 0;
   int   fails = 0;
   ins_t st[3];
   vec_t tab[18];

   function automatic ins_t f_add(input int rd, rs1, rs2);
      ins_t i = '0;
      i.rs = RES_ALU; i.rw = 1'b1; i.alu = ALU_ADD;
      i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
      return i;
   endfunction

   function automatic ins_t f_lw(input int rd, rs1);
      ins_t i = '0;
      i.rs = RES_MEM; i.rw = 1'b1; i.as = 1'b1;
      i.rd = 5'(rd); i.rs1 = 5'(rs1);
      return i;
   endfunction

   function automatic ins_t f_beq(input int rs1, rs2);
      ins_t i = '0;
      i.br = 1'b1; i.alu = ALU_SUB;
      i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
      return i;
   endfunction

   function automatic ins_t f_jal(input int rd);
      ins_t i = '0;
      i.rs = RES_PC4; i.j = 1'b1; i.rw = 1'b1; i.rd = 5'(rd);
      return i;
   endfunction

   // Load-shaped bundle that also branches: lets load-use and a taken branch coincide.
   function automatic ins_t f_odd();
      ins_t i = f_lw(5, 1);
      i.br = 1'b1; i.rs2 = 5'd2; i.alu = ALU_SUB;
      return i;
   endfunction

   function automatic ins_t f_rand();
      ins_t i;
      int r1 = $urandom_range(0, 3);
      int r2 = $urandom_range(0, 3);
      int rd = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
         0: i = f_add(rd, r1, r2);
         1: i = f_lw(rd, r1);
         2: i = f_beq(r1, r2);
         3: i = f_jal(rd);
         4: i = '0;
         default: begin
            i = ins_t'($urandom);
            i.rs1 = 5'(r1); i.rs2 = 5'(r2); i.rd = 5'(rd);
         end
      endcase
      return i;
   endfunction

   function automatic logic writes(input ins_t s);
      return s.rw && s.rd != 0;
   endfunction

   // Nearest older producer still in the pipe supplies the operand.
   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
`ifdef FORWARD_EN
      if (writes(st[1]) && st[1].rd == rs) return 2'b10;
      if (writes(st[2]) && st[2].rd == rs) return 2'b01;
`endif
      return 2'b00;
   endfunction

   // Producers in E (and M, without forwarding) whose result D cannot yet see.
   function automatic logic m_stall(input ins_t d);
      for (int i = 0; i < 2; i++) begin
         if (!writes(st[i])) continue;
         if (st[i].rd != d.rs1 && st[i].rd != d.rs2) continue;
`ifdef FORWARD_EN
         if (i == 0 && st[i].rs == RES_MEM) return 1'b1;
`else
         return 1'b1;
`endif
      end
      return 1'b0;
   endfunction

   function automatic logic [8:0] m_hz(input ins_t d, input logic z);
      logic pc = (st[0].br & z) | st[0].j;
      logic s  = m_stall(d);
      return {pc, s & ~pc, s & ~pc, pc, pc | s,
              m_fwd(st[0].rs1), m_fwd(st[0].rs2)};
   endfunction

   function automatic logic [12:0] m_regs();
      return {st[0].alu, st[0].as, st[1].mw,
              st[2].rw, st[2].rs, st[2].rd};
   endfunction

   function automatic logic [8:0] dut_hz();
      return {bus.PCSrcE, bus.StallF, bus.StallD, bus.FlushD,
              bus.FlushE, bus.ForwardAE, bus.ForwardBE};
   endfunction

   function automatic logic [12:0] dut_regs();
      return {bus.ALUControlE, bus.ALUSrcE, bus.MemWriteM,
              bus.RegWriteW, bus.ResultSrcW, bus.RdW};
   endfunction

   task automatic check(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input ins_t d, input logic z);
      bus.ResultSrcD  = d.rs;
      bus.MemWriteD   = d.mw;
      bus.BranchD     = d.br;
      bus.JumpD       = d.j;
      bus.ALUSrcD     = d.as;
      bus.RegWriteD   = d.rw;
      bus.ALUControlD = d.alu;
      bus.Rs1D        = d.rs1;
      bus.Rs2D        = d.rs2;
      bus.RdD         = d.rd;
      bus.ZeroE       = z;
   endtask

   // Entered at posedge+1; checks at the falling edge, then clocks the model.
   task automatic cycle(input ins_t d, input logic z, input logic rst,
                        input logic use_tab, input logic [8:0] hz_exp,
                        input string tag, output logic hold);
      logic [8:0] mh;
      reset = rst;
      drive(d, z);
      #4;
      mh = m_hz(d, z);
      check({tag, "_hz"}, 16'(dut_hz()), 16'(use_tab ? hz_exp : mh));
      check({tag, "_regs"}, 16'(dut_regs()), 16'(m_regs()));
      hold = mh[6] & ~rst;
      @(posedge clk);
      if (rst) begin
         st[0] = '0; st[1] = '0; st[2] = '0;
      end else begin
         st[2] = st[1];
         st[1] = st[0];
         st[0] = mh[4] ? '0 : d;
      end
      #1;
   endtask

   initial begin
      ins_t cur;
      logic hold;
`ifdef FORWARD_EN
      tab[0]  = '{f_add(5, 1, 2), 1'b0, H_0};
      tab[1]  = '{f_add(6, 5, 1), 1'b0, H_0};
      tab[2]  = '{f_add(7, 1, 5), 1'b0, H_AM};
      tab[3]  = '{ins_t'('0),     1'b0, H_BW};
      tab[4]  = '{f_lw(5, 1),     1'b0, H_0};
      tab[5]  = '{f_add(6, 5, 1), 1'b0, H_ST};
      tab[6]  = '{f_add(6, 5, 1), 1'b0, H_0};
      tab[7]  = '{ins_t'('0),     1'b0, H_AW};
`else
      tab[0]  = '{f_add(5, 1, 2), 1'b0, H_0};
      tab[1]  = '{f_add(6, 5, 1), 1'b0, H_ST};
      tab[2]  = '{f_add(6, 5, 1), 1'b0, H_ST};
      tab[3]  = '{f_add(6, 5, 1), 1'b0, H_0};
      tab[4]  = '{f_lw(5, 1),     1'b0, H_0};
      tab[5]  = '{f_add(7, 5, 1), 1'b0, H_ST};
      tab[6]  = '{f_add(7, 5, 1), 1'b0, H_ST};
      tab[7]  = '{f_add(7, 5, 1), 1'b0, H_0};
`endif
      tab[8]  = '{f_beq(1, 2),    1'b0, H_0};
      tab[9]  = '{ins_t'('0),     1'b1, H_BR};
      tab[10] = '{f_beq(1, 2),    1'b0, H_0};
      tab[11] = '{ins_t'('0),     1'b0, H_0};
      tab[12] = '{f_odd(),        1'b0, H_0};
      tab[13] = '{f_add(6, 5, 1), 1'b1, H_BR};
      tab[14] = '{f_add(0, 1, 2), 1'b0, H_0};
      tab[15] = '{f_add(6, 0, 0), 1'b0, H_0};
      tab[16] = '{ins_t'('0),     1'b0, H_0};
      tab[17] = '{ins_t'('0),     1'b0, H_0};

      // Reset held two edges while a jal x5 is presented.
      reset = 1'b1;
      drive(f_jal(5), 1'b1);
      st[0] = '0; st[1] = '0; st[2] = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_hz", 16'(dut_hz()), 16'h0);
      check("reset_regs", 16'(dut_regs()), 16'h0);
      reset = 1'b0;
      #1;
      check("post_reset_pcsrc", 16'(bus.PCSrcE), 16'h0);
      check("post_reset_hz", 16'(dut_hz()), 16'h0);
      @(posedge clk);
      #1;
      st[0] = f_jal(5);
      check("jal_pcsrc", 16'(bus.PCSrcE), 16'h1);
      cycle('0, 1'b0, 1'b1, 1'b0, H_0, "rst_mid", hold);
      check("rst_mid_clear", 16'(dut_hz()), 16'h0);

      for (int k = 0; k < 18; k++)
         cycle(tab[k].d, tab[k].z, 1'b0, 1'b1, tab[k].hz,
               $sformatf("vec%0d", k), hold);

      hold = 1'b0;
      cur  = '0;
      for (int k = 0; k < 600; k++) begin
         logic rst;
         rst = ($urandom_range(0, 24) == 0);
         if (!hold) cur = f_rand();
         cycle(cur, 1'($urandom_range(0, 1)), rst, 1'b0, H_0,
               $sformatf("rnd%0d", k), hold);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
